// File: rtl/storage_arbiter_pkg.sv
// Shared definitions for the matrix storage arbiter: requester ids, widths and id helpers.
// The storage RAM and the sequencing controller use the same width constants.
package storage_arbiter_pkg;

  localparam int NREQ         = 3;
  localparam int STORE_ADDR_W = 9;
  localparam int STORE_DATA_W = 32;

  localparam logic [1:0] ID_INPUT = 2'd0;
  localparam logic [1:0] ID_DISP  = 2'd1;
  localparam logic [1:0] ID_CALC  = 2'd2;
  localparam logic [1:0] ID_NONE  = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_t;

  function automatic logic [1:0] onehot_to_id(input logic [NREQ-1:0] oh);
    logic [1:0] id;
    id = ID_NONE;
    if (oh[0])      id = ID_INPUT;
    else if (oh[1]) id = ID_DISP;
    else if (oh[2]) id = ID_CALC;
    return id;
  endfunction

  function automatic logic [NREQ-1:0] id_to_onehot(input logic [1:0] id);
    logic [NREQ-1:0] oh;
    oh = '0;
    case (id)
      ID_INPUT: oh = 3'b001;
      ID_DISP:  oh = 3'b010;
      ID_CALC:  oh = 3'b100;
      default:  oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/storage_arbiter_rr_picker.sv
// Combinational 3-way round-robin select: first set request after 'last', wrapping.
// A 'last' of ID_NONE behaves like ID_CALC, so input is scanned first.
module rr_picker
  import storage_arbiter_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      last,
  output logic [NREQ-1:0] winner,
  output logic            valid
);

  always_comb begin
    winner = '0;
    case (last)
      ID_INPUT: begin
        if (req[1])      winner = 3'b010;
        else if (req[2]) winner = 3'b100;
        else if (req[0]) winner = 3'b001;
      end
      ID_DISP: begin
        if (req[2])      winner = 3'b100;
        else if (req[0]) winner = 3'b001;
        else if (req[1]) winner = 3'b010;
      end
      default: begin
        if (req[0])      winner = 3'b001;
        else if (req[1]) winner = 3'b010;
        else if (req[2]) winner = 3'b100;
      end
    endcase
  end

  assign valid = |req;

endmodule

// File: rtl/storage_arbiter.sv
// Request/grant arbiter sharing the single-port matrix storage between input,
// display and calculator, with burst lock, bounded hold and id-tagged read return.
//
//   state   | meaning
//   --------+----------------------------------------------
//   ST_IDLE | no grant; arbitrate every cycle
//   ST_OWN  | one owner holds o_gnt until its release condition
module storage_arbiter
  import storage_arbiter_pkg::*;
#(
  parameter int ADDR_W   = STORE_ADDR_W,
  parameter int DATA_W   = STORE_DATA_W,
  parameter int RD_LAT   = 1,
  parameter int MAX_HOLD = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        i_req,
  input  logic [NREQ-1:0]        i_lock,
  input  logic [NREQ-1:0]        i_we,
  input  logic [NREQ*ADDR_W-1:0] i_addr,
  input  logic [NREQ*DATA_W-1:0] i_wdata,
  output logic [NREQ-1:0]        o_gnt,
  output logic [NREQ-1:0]        o_rvalid,
  output logic [DATA_W-1:0]      o_rdata,
  output logic                   o_busy,
  output logic [1:0]             o_owner,
  output logic                   o_mem_we,
  output logic [ADDR_W-1:0]      o_mem_addr,
  output logic [DATA_W-1:0]      o_mem_wdata,
  input  logic [DATA_W-1:0]      i_mem_rdata
);

  arb_state_t        state;
  logic [1:0]        last_q;
  logic [7:0]        hold_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [RD_LAT-1:0] pipe_v;
  logic [1:0]        pipe_id [RD_LAT];

  logic            owner_req;
  logic            owner_lock;
  logic            owner_we;
  logic            others_req;
  logic            beat;
  logic            read_beat;
  logic            hold_hit;
  logic            release_own;
  logic            arbitrate;
  logic [1:0]      pick_last;
  logic [NREQ-1:0] win_oh;
  logic            win_valid;

  // o_gnt is one-hot and zero in idle, so masking with it selects the owner's bits
  assign owner_req  = |(i_req & o_gnt);
  assign owner_lock = |(i_lock & o_gnt);
  assign owner_we   = |(i_we & o_gnt);
  assign others_req = |(i_req & ~o_gnt);
  assign beat       = owner_req;
  assign read_beat  = beat & ~owner_we;

  // Hold counts only contended unlocked beats, so a lone streamer is never cut short
  assign hold_hit    = beat && !owner_lock && others_req && (hold_cnt == 8'(MAX_HOLD - 1));
  assign release_own = (state == ST_OWN) && (!owner_req || hold_hit);
  assign arbitrate   = (state == ST_IDLE) || release_own;

  // Releasing owner is scanned last, so a preempted requester yields to the others
  assign pick_last = (state == ST_OWN) ? o_owner : last_q;

  rr_picker u_rr_picker (
    .req    (i_req),
    .last   (pick_last),
    .winner (win_oh),
    .valid  (win_valid)
  );

  always_comb begin
    o_mem_addr  = addr_q;
    o_mem_wdata = wdata_q;
    if (beat) begin
      case (o_owner)
        ID_INPUT: begin
          o_mem_addr  = i_addr[0*ADDR_W +: ADDR_W];
          o_mem_wdata = i_wdata[0*DATA_W +: DATA_W];
        end
        ID_DISP: begin
          o_mem_addr  = i_addr[1*ADDR_W +: ADDR_W];
          o_mem_wdata = i_wdata[1*DATA_W +: DATA_W];
        end
        ID_CALC: begin
          o_mem_addr  = i_addr[2*ADDR_W +: ADDR_W];
          o_mem_wdata = i_wdata[2*DATA_W +: DATA_W];
        end
        default: ;
      endcase
    end
  end

  assign o_mem_we = beat & owner_we;
  assign o_rdata  = i_mem_rdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      o_gnt    <= '0;
      o_owner  <= ID_NONE;
      o_busy   <= 1'b0;
      last_q   <= ID_CALC;
      hold_cnt <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      addr_q  <= o_mem_addr;
      wdata_q <= o_mem_wdata;
      if (release_own) last_q <= o_owner;
      if (arbitrate) begin
        hold_cnt <= '0;
        if (win_valid) begin
          state   <= ST_OWN;
          o_gnt   <= win_oh;
          o_owner <= onehot_to_id(win_oh);
          o_busy  <= 1'b1;
        end else begin
          state   <= ST_IDLE;
          o_gnt   <= '0;
          o_owner <= ID_NONE;
          o_busy  <= 1'b0;
        end
      end else if (beat && !owner_lock && others_req && (hold_cnt != 8'(MAX_HOLD))) begin
        hold_cnt <= hold_cnt + 8'd1;
      end
    end
  end

  // Read id pipeline; the id travels with the beat so a grant change cannot misroute it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipe_v <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe_id[i] <= ID_NONE;
    end else begin
      pipe_v[0]  <= read_beat;
      pipe_id[0] <= o_owner;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v[i]  <= pipe_v[i-1];
        pipe_id[i] <= pipe_id[i-1];
      end
    end
  end

  assign o_rvalid = pipe_v[RD_LAT-1] ? id_to_onehot(pipe_id[RD_LAT-1]) : '0;

endmodule
